// File: rtl/rom_write_ctrl.sv
// rom_write_ctrl: write controller for a 32x8 store, driven by two pushbuttons.
//
// Load and Clear are bouncy, asynchronous buttons. Each one is synchronized,
// debounced and edge-detected into a one-cycle press event. In IDLE, a Load
// press writes D to the target address. A Clear press writes 8'h00 to the
// target address. A press is ignored while the other button is held down.
// With Auto=1 the target is an internal pointer. The pointer advances after
// each Load write.
//
// Optional feature: define CLEAR_SWEEP_EN to make a Clear press with Auto=1
// zero the whole store. This writes 32 strobes to addresses 0..31 and then
// resets the pointer to 0.
//
// Parameters:
//   DB_COUNT  consecutive stable cycles needed to accept a button level change
// Ports:
//   Clk    clock, rising edge
//   Rst_n  asynchronous active-low reset
//   Load   raw left button
//   Clear  raw right button
//   D      data switches
//   A      address switches
//   Auto   auto-increment mode switch
//   We     single-cycle write strobe (held for 32 cycles during a sweep)
//   Wa     write address, registered
//   Wd     write data, registered
//   Ao     next target address for display, registered
//   Busy   high whenever the controller is not idle

// Per-button front end: 2-flop synchronizer, debouncer, rising-edge detector.
module rom_write_ctrl_btn #(
   parameter int DB_COUNT = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int CW = 20;

   logic          s1, s2;
   logic [CW-1:0] cnt;
   logic          level_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         level_d <= level;
         // Any cycle that agrees with the accepted level restarts the count,
         // so bounces shorter than DB_COUNT cycles are never accepted.
         if (s2 != level) begin
            if (cnt == CW'(DB_COUNT - 1)) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press = level & ~level_d;
endmodule

module rom_write_ctrl #(
   parameter int DB_COUNT = 500000
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Load,
   input  logic       Clear,
   input  logic [7:0] D,
   input  logic [4:0] A,
   input  logic       Auto,
   output logic       We,
   output logic [4:0] Wa,
   output logic [7:0] Wd,
   output logic [4:0] Ao,
   output logic       Busy
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
`ifdef CLEAR_SWEEP_EN
   localparam logic [1:0] S_SWEEP = 2'd2;
`endif

   // Index 0 is Load and index 1 is Clear.
   logic [1:0] raw, lvl, press;
   logic [1:0] state;
   logic [4:0] ptr;
   logic [4:0] target;
   logic       op_load;
   logic       ld_ev, cl_ev;

   assign raw = {Clear, Load};

   for (genvar g = 0; g < 2; g++) begin : g_btn
      rom_write_ctrl_btn #(.DB_COUNT(DB_COUNT)) u_btn (
         .clk   (Clk),
         .rst_n (Rst_n),
         .raw   (raw[g]),
         .level (lvl[g]),
         .press (press[g])
      );
   end

   // A press event always has its own level high. So simultaneous presses
   // cancel each other out through the other-level-low qualifier.
   assign ld_ev  = press[0] & ~lvl[1];
   assign cl_ev  = press[1] & ~lvl[0];
   assign target = Auto ? ptr : A;
   assign Busy   = (state != S_IDLE);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= S_IDLE;
         We      <= 1'b0;
         Wa      <= '0;
         Wd      <= '0;
         Ao      <= '0;
         op_load <= 1'b0;
      end else begin
         Ao <= target;
         case (state)
            S_IDLE: begin
               We <= 1'b0;
               if (ld_ev) begin
                  state   <= S_WRITE;
                  We      <= 1'b1;
                  Wa      <= target;
                  Wd      <= D;
                  op_load <= 1'b1;
               end else if (cl_ev) begin
`ifdef CLEAR_SWEEP_EN
                  if (Auto) begin
                     state   <= S_SWEEP;
                     We      <= 1'b1;
                     Wa      <= '0;
                     Wd      <= '0;
                     op_load <= 1'b0;
                  end else
`endif
                  begin
                     state   <= S_WRITE;
                     We      <= 1'b1;
                     Wa      <= target;
                     Wd      <= '0;
                     op_load <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               // The strobe was raised on entry. Drop it and go back to IDLE.
               // Presses that arrive in this cycle are discarded.
               We    <= 1'b0;
               state <= S_IDLE;
            end
`ifdef CLEAR_SWEEP_EN
            S_SWEEP: begin
               if (Wa == 5'd31) begin
                  We    <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  Wa <= Wa + 5'd1;
               end
            end
`endif
            default: begin
               We    <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Pointer tracks the switches in manual mode.
   // In auto mode it advances after each Load write.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr <= '0;
      end else if (!Auto) begin
         ptr <= A;
      end else if (state == S_WRITE && op_load) begin
         ptr <= ptr + 5'd1;
      end
`ifdef CLEAR_SWEEP_EN
      else if (state == S_SWEEP && Wa == 5'd31) begin
         ptr <= '0;
      end
`endif
   end
endmodule

// File: tb/tb_rom_write_ctrl.sv
module tb_rom_write_ctrl;
   localparam int DB = 4;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       Load = 1'b0;
   logic       Clear = 1'b0;
   logic       Auto = 1'b0;
   logic [7:0] D = '0;
   logic [4:0] A = '0;
   logic       We, Busy;
   logic [4:0] Wa, Ao;
   logic [7:0] Wd;

   rom_write_ctrl #(.DB_COUNT(DB)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .Clear(Clear), .D(D), .A(A),
      .Auto(Auto), .We(We), .Wa(Wa), .Wd(Wd), .Ao(Ao), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0] wa;
      logic [7:0] wd;
      int         cyc;
   } wr_t;

   int  n_checks = 0;
   int  n_fail = 0;
   int  cyc_cnt = 0;
   wr_t obs[$];
   bit  busy_seen = 0;

   // Write monitor: records every strobed cycle.
   always @(negedge Clk) begin
      cyc_cnt++;
      if (We === 1'b1) obs.push_back('{wa: Wa, wd: Wd, cyc: cyc_cnt});
      if (Busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (Busy !== 1'b0 && t < 200) begin
         cyc(1);
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: Busy=%b after %0d cycles, required 0", Busy, t);
      end
   endtask

   task automatic press(input bit is_load, input int hold);
      if (is_load) Load = 1'b1; else Clear = 1'b1;
      cyc(hold);
      Load  = 1'b0;
      Clear = 1'b0;
      cyc(12);
      wait_idle();
      cyc(2);
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      A     = 5'd9;
      D     = 8'h3C;
      cyc(3);
      n_checks++; if (We !== 1'b0)  begin n_fail++; $display("FAIL reset_we: got %b want 0", We); end
      n_checks++; if (Wa !== 5'd0)  begin n_fail++; $display("FAIL reset_wa: got %0d want 0", Wa); end
      n_checks++; if (Wd !== 8'h00) begin n_fail++; $display("FAIL reset_wd: got %h want 00", Wd); end
      n_checks++; if (Ao !== 5'd0)  begin n_fail++; $display("FAIL reset_ao: got %0d want 0", Ao); end
      n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      Rst_n = 1'b1;
      cyc(2);
      n_checks++; if (Ao !== 5'd9) begin n_fail++; $display("FAIL post_reset_ao: got %0d want 9", Ao); end
   endtask

   task automatic test_single_load();
      int t0;
      A = 5'd3;
      D = 8'hA5;
      cyc(2);
      obs.delete();
      t0 = cyc_cnt;
      Load = 1'b1;
      cyc(30);
      n_checks++;
      if (obs.size() != 1) begin
         n_fail++;
         $display("FAIL single_count: got %0d writes want 1", obs.size());
      end else begin
         n_checks++; if (obs[0].wa !== 5'd3)  begin n_fail++; $display("FAIL single_wa: got %0d want 3", obs[0].wa); end
         n_checks++; if (obs[0].wd !== 8'hA5) begin n_fail++; $display("FAIL single_wd: got %h want a5", obs[0].wd); end
         n_checks++;
         if (obs[0].cyc - t0 < DB + 2 || obs[0].cyc - t0 > DB + 5) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles want %0d..%0d", obs[0].cyc - t0, DB + 2, DB + 5);
         end
      end
      Load = 1'b0;
      cyc(30);
      n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL release_write: got %0d writes want 1", obs.size()); end
   endtask

   task automatic test_bounce();
      D = 8'h5A;
      obs.delete();
      for (int i = 0; i < 10; i++) begin
         Load = (i % 2 == 0);
         cyc(2);
      end
      Load = 1'b1;
      cyc(30);
      Load = 1'b0;
      cyc(30);
      n_checks++;
      if (obs.size() != 1) begin
         n_fail++;
         $display("FAIL bounce_count: got %0d writes want 1", obs.size());
      end else begin
         n_checks++; if (obs[0].wd !== 8'h5A) begin n_fail++; $display("FAIL bounce_wd: got %h want 5a", obs[0].wd); end
      end
   endtask

   task automatic test_auto();
      logic [7:0] dv[3] = '{8'd11, 8'd22, 8'd33};
      logic [4:0] av[3] = '{5'd30, 5'd31, 5'd0};
      Auto = 1'b0;
      A    = 5'd30;
      cyc(3);
      Auto = 1'b1;
      cyc(2);
      obs.delete();
      for (int i = 0; i < 3; i++) begin
         D = dv[i];
         press(1'b1, 10);
      end
      n_checks++;
      if (obs.size() != 3) begin
         n_fail++;
         $display("FAIL auto_count: got %0d writes want 3", obs.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i].wa !== av[i] || obs[i].wd !== dv[i]) begin
               n_fail++;
               $display("FAIL auto_write%0d: got %0d/%0d want %0d/%0d", i, obs[i].wa, obs[i].wd, av[i], dv[i]);
            end
         end
      end
      n_checks++; if (Ao !== 5'd1) begin n_fail++; $display("FAIL auto_ao: got %0d want 1", Ao); end
      Auto = 1'b0;
      cyc(2);
   endtask

   task automatic test_simultaneous();
      obs.delete();
      busy_seen = 1'b0;
      Load  = 1'b1;
      Clear = 1'b1;
      cyc(30);
      Load  = 1'b0;
      Clear = 1'b0;
      cyc(30);
      n_checks++; if (obs.size() != 0) begin n_fail++; $display("FAIL simul_we: got %0d writes want 0", obs.size()); end
      n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL simul_busy: got %b want 0", busy_seen); end
   endtask

   task automatic test_clear();
      Auto = 1'b0;
      A    = 5'd12;
      D    = 8'hFF;
      cyc(3);
      obs.delete();
      press(1'b0, 10);
      n_checks++;
      if (obs.size() != 1 || obs[0].wa !== 5'd12 || obs[0].wd !== 8'h00) begin
         n_fail++;
         $display("FAIL clear_manual: got %0d writes first %0d/%h want 1 write 12/00",
                  obs.size(), obs.size() ? obs[0].wa : 5'd0, obs.size() ? obs[0].wd : 8'd0);
      end
`ifndef CLEAR_SWEEP_EN
      A = 5'd7;
      cyc(3);
      Auto = 1'b1;
      cyc(2);
      obs.delete();
      press(1'b0, 10);
      n_checks++;
      if (obs.size() != 1 || obs[0].wa !== 5'd7 || obs[0].wd !== 8'h00) begin
         n_fail++;
         $display("FAIL clear_auto: got %0d writes, want 1 write 7/00", obs.size());
      end
      n_checks++; if (Ao !== 5'd7) begin n_fail++; $display("FAIL clear_auto_ptr: got %0d want 7", Ao); end
      Auto = 1'b0;
      cyc(2);
`endif
   endtask

`ifdef CLEAR_SWEEP_EN
   task automatic test_sweep();
      int bad;
      int t;
      Auto = 1'b0;
      A    = 5'd5;
      cyc(3);
      Auto = 1'b1;
      cyc(2);
      obs.delete();
      press(1'b0, 10);
      n_checks++;
      if (obs.size() != 32) begin
         n_fail++;
         $display("FAIL sweep_count: got %0d writes want 32", obs.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 32; i++)
            if (obs[i].wa !== 5'(i) || obs[i].wd !== 8'h00 || obs[i].cyc != obs[0].cyc + i) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sweep_seq: got %0d bad entries want 0", bad); end
      end
      n_checks++; if (Ao !== 5'd0) begin n_fail++; $display("FAIL sweep_ptr: got %0d want 0", Ao); end
      // Second sweep, aborted by reset partway through.
      obs.delete();
      Clear = 1'b1;
      t = 0;
      while (obs.size() < 10 && t < 100) begin
         cyc(1);
         #1;
         t++;
      end
      n_checks++; if (t >= 100) begin n_fail++; $display("FAIL sweep2_start: got %0d writes want 10", obs.size()); end
      Rst_n = 1'b0;
      #1;
      n_checks++; if (We !== 1'b0)   begin n_fail++; $display("FAIL sweep_abort_we: got %b want 0", We); end
      n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL sweep_abort_busy: got %b want 0", Busy); end
      Clear = 1'b0;
      cyc(3);
      Rst_n = 1'b1;
      obs.delete();
      cyc(50);
      n_checks++; if (obs.size() != 0) begin n_fail++; $display("FAIL sweep_after_abort: got %0d writes want 0", obs.size()); end
      Auto = 1'b0;
      cyc(2);
   endtask
`endif

   task automatic test_random();
      wr_t        exp_q[$];
      logic [4:0] m_ptr;
      logic [4:0] tgt;
      logic [4:0] av;
      logic [7:0] dv;
      bit         au, is_load;
      int         bad;
      Auto = 1'b0;
      A    = 5'd0;
      cyc(3);
      m_ptr = 5'd0;
      obs.delete();
      for (int i = 0; i < 14; i++) begin
         au      = 1'($urandom_range(0, 1));
         is_load = 1'($urandom_range(0, 1));
         av      = 5'($urandom);
         dv      = 8'($urandom);
         Auto = au;
         A    = av;
         D    = dv;
         if (!au) m_ptr = av;
         cyc(3);
         tgt = au ? m_ptr : av;
         if (is_load) begin
            exp_q.push_back('{wa: tgt, wd: dv, cyc: 0});
            if (au) m_ptr = m_ptr + 5'd1;
         end else begin
`ifdef CLEAR_SWEEP_EN
            if (au) begin
               for (int k = 0; k < 32; k++) exp_q.push_back('{wa: 5'(k), wd: 8'h00, cyc: 0});
               m_ptr = 5'd0;
            end else
`endif
            exp_q.push_back('{wa: tgt, wd: 8'h00, cyc: 0});
         end
         press(is_load, $urandom_range(8, 14));
      end
      n_checks++;
      if (obs.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_count: got %0d writes want %0d", obs.size(), exp_q.size());
      end else begin
         bad = 0;
         foreach (exp_q[i]) if (obs[i].wa !== exp_q[i].wa || obs[i].wd !== exp_q[i].wd) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL random_writes: got %0d mismatched want 0", bad); end
      end
      n_checks++;
      if (Ao !== (Auto ? m_ptr : A)) begin
         n_fail++;
         $display("FAIL random_ao: got %0d want %0d", Ao, Auto ? m_ptr : A);
      end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_bounce();
      test_auto();
      test_simultaneous();
      test_clear();
`ifdef CLEAR_SWEEP_EN
      test_sweep();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
